daa_io_frame_assembler: RTL

Input front-end placed between the user-area pad inputs (io_in[27:11], 17 pins) and the core datapath. It synchronises the asynchronous pad bus, detects the external byte strobe, and packs strobed bytes into 32-bit little-endian words that belong to start-of-frame-delimited frames. It buffers the words in a small FIFO and presents them to the core over a valid/ready handshake. It also passes the pad configuration bits through, synchronised.

---
 rtl/daa_io_pkg.sv | 24 ++
 rtl/daa_sync_fifo.sv | 58 +++++
 rtl/daa_io_frame_assembler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/daa_io_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// daa_io_pkg : pad map, assembler state type and word geometry.  Rev 1.0
// ---------------------------------------------------------------------------
package daa_io_pkg;

  localparam int PAD_DATA_LSB = 0;
  localparam int PAD_STB      = 8;
  localparam int PAD_SOF      = 9;
  localparam int PAD_CFG_LSB  = 10;
  localparam int PAD_CFG_W    = 7;
  localparam int PAD_W        = 17;

  localparam int DEF_DATA_W         = 8;
  localparam int DEF_BYTES_PER_WORD = 4;
  localparam int WORD_W             = DEF_DATA_W * DEF_BYTES_PER_WORD;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    ASSEMBLE = 1'b1
  } daa_io_state_t;

endpackage
`default_nettype wire

// File: rtl/daa_sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// daa_sync_fifo : FWFT synchronous FIFO with level and same-cycle push/pop.  Rev 1.0
// ---------------------------------------------------------------------------
module daa_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr;
  logic [c_AW-1:0]  r_rd;
  logic [c_AW:0]    r_cnt;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_cnt == (c_AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop frees the slot in the same edge, so a full FIFO can still accept.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = o_empty ? '0 : r_mem[r_rd];
  assign o_level   = r_cnt;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/daa_io_frame_assembler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// daa_io_frame_assembler : pad sync, strobe edge detect, byte-to-word framing.  Rev 1.0
// ---------------------------------------------------------------------------
module daa_io_frame_assembler
  import daa_io_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  input  logic [PAD_W-1:0]                  pad_in,
  output logic [PAD_CFG_W-1:0]              cfg_o,
  output logic [DATA_W*BYTES_PER_WORD-1:0]  word_data_o,
  output logic                              word_sof_o,
  output logic                              word_valid_o,
  input  logic                              word_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level_o,
  output logic                              overflow_o,
  output logic                              frame_err_o,
  input  logic                              clr_err_i
);

  localparam int c_WORD_W = DATA_W * BYTES_PER_WORD;
  localparam int c_CNT_W  = $clog2(BYTES_PER_WORD);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BYTES_PER_WORD - 1);

  logic [PAD_W-1:0]     r_sync [SYNC_STAGES];
  logic [PAD_W-1:0]     w_sync;
  logic                 r_stb_d;
  logic                 w_rise;
  logic [DATA_W-1:0]    w_byte;
  logic                 w_sof;

  daa_io_state_t        r_state, w_state_nx;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic                 r_first, w_first_nx;
  logic [c_WORD_W-1:0]  r_word, w_word_nx, w_lane_word;
  logic                 w_push, w_err_set;
  logic [c_WORD_W:0]    w_push_data, w_head;
  logic                 w_full, w_empty, w_pop;
  logic                 r_ovf, r_ferr;

  // Every pad bit shares one chain so strobe, sof and data stay aligned.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_sync[gi] <= '0;
        else          r_sync[gi] <= pad_in;
      end
    end else begin : g_rest
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_sync[gi] <= '0;
        else          r_sync[gi] <= r_sync[gi-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_byte = w_sync[PAD_DATA_LSB +: DATA_W];
  assign w_sof  = w_sync[PAD_SOF];
  assign w_rise = w_sync[PAD_STB] & ~r_stb_d;
  assign cfg_o  = w_sync[PAD_CFG_LSB +: PAD_CFG_W];

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_first_nx  = r_first;
    w_word_nx   = r_word;
    w_push      = 1'b0;
    w_err_set   = 1'b0;
    w_lane_word = r_word;
    w_lane_word[int'(r_cnt)*DATA_W +: DATA_W] = w_byte;
    w_push_data = {r_first, w_lane_word};
    if (w_rise) begin
      if (w_sof) begin
        w_err_set  = (r_state == ASSEMBLE) && (r_cnt != '0);
        w_state_nx = ASSEMBLE;
        w_word_nx  = {{(c_WORD_W-DATA_W){1'b0}}, w_byte};
        w_cnt_nx   = c_CNT_W'(1);
        w_first_nx = 1'b1;
      end else if (r_state == IDLE) begin
        w_err_set  = 1'b1;
      end else if (r_cnt == c_LAST) begin
        w_push     = 1'b1;
        w_word_nx  = w_lane_word;
        w_cnt_nx   = '0;
        w_first_nx = 1'b0;
      end else begin
        w_word_nx  = w_lane_word;
        w_cnt_nx   = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_stb_d <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_first <= 1'b0;
      r_word  <= '0;
    end else begin
      r_stb_d <= w_sync[PAD_STB];
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_first <= w_first_nx;
      r_word  <= w_word_nx;
    end
  end

  assign w_pop = word_valid_o & word_ready_i;

  daa_sync_fifo #(
    .WIDTH (c_WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level_o)
  );

  assign word_data_o  = w_head[c_WORD_W-1:0];
  assign word_sof_o   = w_head[c_WORD_W];
  assign word_valid_o = ~w_empty;

  // Set has priority over clear so an error in the clearing cycle is kept.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
      else if (clr_err_i)           r_ovf <= 1'b0;
      if (w_err_set)                r_ferr <= 1'b1;
      else if (clr_err_i)           r_ferr <= 1'b0;
    end
  end

  assign overflow_o  = r_ovf;
  assign frame_err_o = r_ferr;

endmodule
`default_nettype wire
